// File: rtl/ahb_slave_if_param_pkg.sv
// Shared encodings for the AHB slave front end: transfer types, responses,
// and the error-response FSM state type.
package ahb_slave_if_param_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    localparam logic [15:0] XFER_CNT_MAX = 16'hFFFF;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_if_param_decode.sv
// Address region decoder: NSEL contiguous power-of-two regions starting at BASE.
// Produces an in-range flag and a one-hot region select.
module ahb_region_decode #(
    parameter int                ADDR_W = 32,
    parameter int                NSEL   = 3,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION = 32'h0400_0000
) (
    input  logic [ADDR_W-1:0] haddr,
    output logic              in_range,
    output logic [NSEL-1:0]   sel
);

    localparam int          RSH   = $clog2(REGION);
    localparam logic [63:0] LIMIT = 64'(NSEL) << RSH;

    logic [ADDR_W:0] w_diff;
    logic [63:0]     w_off;
    logic [63:0]     w_idx;

    // Extra MSB on the subtraction doubles as the "below BASE" borrow flag.
    assign w_diff   = {1'b0, haddr} - {1'b0, BASE};
    assign w_off    = 64'(w_diff[ADDR_W-1:0]);
    assign w_idx    = w_off >> RSH;
    assign in_range = ~w_diff[ADDR_W] && (w_off < LIMIT);

    for (genvar k = 0; k < NSEL; k++) begin : g_sel
        assign sel[k] = in_range && (w_idx == 64'(k));
    end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB slave interface of an AHB-to-APB bridge: region decode, address/data
// delay lines, registered control, two-cycle ERROR response, transfer counter.
module ahb_slave_if_param
    import ahb_slave_if_param_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                NSEL   = 3,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION = 32'h0400_0000,
    parameter int                PIPE   = 2
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hwrite,
    input  logic                     hreadyin,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hsize,
    input  logic [ADDR_W-1:0]        haddr,
    input  logic [DATA_W-1:0]        hwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     stall,
    output logic [PIPE*ADDR_W-1:0]   haddr_q,
    output logic [PIPE*DATA_W-1:0]   hwdata_q,
    output logic [DATA_W-1:0]        hrdata,
    output logic                     valid,
    output logic                     hwritereg,
    output logic [NSEL-1:0]          tempselx,
    output logic [2:0]               psize,
    output logic                     hreadyout,
    output logic [1:0]               hresp,
    output logic [15:0]              xfer_cnt
);

    logic                           w_in_range;
    logic                           w_active;
    logic                           w_accept;
    err_state_e                     r_state;
    err_state_e                     w_state_nxt;
    logic [PIPE-1:0][ADDR_W-1:0]    r_haddr_q;
    logic [PIPE-1:0][DATA_W-1:0]    r_hwdata_q;
    logic                           r_hwritereg;
    logic [2:0]                     r_psize;
    logic [15:0]                    r_xfer_cnt;

    ahb_region_decode #(
        .ADDR_W (ADDR_W),
        .NSEL   (NSEL),
        .BASE   (BASE),
        .REGION (REGION)
    ) u_decode (
        .haddr    (haddr),
        .in_range (w_in_range),
        .sel      (tempselx)
    );

    assign w_active = is_active(htrans);
    // hreadyout is ~stall whenever the FSM is idle, so it is folded in here
    // directly to keep accept free of a path through the output logic.
    assign w_accept = hreadyin && w_active && (r_state == ST_IDLE) && !stall;
    assign valid    = hreadyin && w_active && w_in_range && (r_state == ST_IDLE);
    assign hrdata   = prdata;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        hreadyout   = 1'b1;
        hresp       = HRESP_OKAY;
        case (r_state)
            ST_IDLE: begin
                hreadyout = ~stall;
                if (w_accept && !w_in_range) w_state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                hreadyout   = 1'b0;
                hresp       = HRESP_ERROR;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp       = HRESP_ERROR;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Slot 0 takes the current bus values; older slots move toward PIPE-1.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_haddr_q  <= '0;
            r_hwdata_q <= '0;
        end else if (hreadyin) begin
            r_haddr_q[0]  <= haddr;
            r_hwdata_q[0] <= hwdata;
            for (int i = 1; i < PIPE; i++) begin
                r_haddr_q[i]  <= r_haddr_q[i-1];
                r_hwdata_q[i] <= r_hwdata_q[i-1];
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hwritereg <= 1'b0;
            r_psize     <= '0;
            r_xfer_cnt  <= '0;
        end else if (w_accept) begin
            r_hwritereg <= hwrite;
            r_psize     <= hsize;
            if (w_in_range && (r_xfer_cnt != XFER_CNT_MAX))
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign haddr_q   = r_haddr_q;
    assign hwdata_q  = r_hwdata_q;
    assign hwritereg = r_hwritereg;
    assign psize     = r_psize;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle number,
// a negedge monitor pops and compares them against the DUT.
module tb_ahb_slave_if_param;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;
    localparam int PIPE   = 2;

    localparam int F_SEL = 0, F_VLD = 1, F_RDY = 2, F_RSP = 3, F_CNT = 4;
    localparam int F_WR  = 5, F_PSZ = 6, F_WDQ = 7, F_ADQ = 8, F_RD  = 9;

    logic                   hclk = 1'b0;
    logic                   hreset = 1'b1;
    logic                   hwrite = 1'b0;
    logic                   hreadyin = 1'b1;
    logic [1:0]             htrans = 2'b00;
    logic [2:0]             hsize = 3'd0;
    logic [ADDR_W-1:0]      haddr = '0;
    logic [DATA_W-1:0]      hwdata = '0;
    logic [DATA_W-1:0]      prdata = '0;
    logic                   stall = 1'b0;
    logic [PIPE*ADDR_W-1:0] haddr_q;
    logic [PIPE*DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0]      hrdata;
    logic                   valid;
    logic                   hwritereg;
    logic [NSEL-1:0]        tempselx;
    logic [2:0]             psize;
    logic                   hreadyout;
    logic [1:0]             hresp;
    logic [15:0]            xfer_cnt;

    ahb_slave_if_param dut (
        .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
        .prdata(prdata), .stall(stall), .haddr_q(haddr_q), .hwdata_q(hwdata_q),
        .hrdata(hrdata), .valid(valid), .hwritereg(hwritereg),
        .tempselx(tempselx), .psize(psize), .hreadyout(hreadyout),
        .hresp(hresp), .xfer_cnt(xfer_cnt)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int          cyc;
        int          fld;
        logic [63:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    function automatic logic [63:0] probe(input int f);
        case (f)
            F_SEL:   return 64'(tempselx);
            F_VLD:   return 64'(valid);
            F_RDY:   return 64'(hreadyout);
            F_RSP:   return 64'(hresp);
            F_CNT:   return 64'(xfer_cnt);
            F_WR:    return 64'(hwritereg);
            F_PSZ:   return 64'(psize);
            F_WDQ:   return 64'(hwdata_q);
            F_ADQ:   return 64'(haddr_q);
            F_RD:    return 64'(hrdata);
            default: return 64'hX;
        endcase
    endfunction

    always @(negedge hclk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [63:0] got;
            e   = q.pop_front();
            got = probe(e.fld);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation from cycle %0d not sampled (now %0d)", e.nm, e.cyc, cyc);
            end else if (got !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h want %h", e.nm, cyc, got, e.val);
            end
        end
    end

    task automatic chk(input int f, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.fld = f; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic drv(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] s, input logic rdy, input logic st);
        @(posedge hclk);
        #1;
        hreset = 1'b0; htrans = t; haddr = a; hwdata = d;
        hwrite = w; hsize = s; hreadyin = rdy; stall = st;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge hclk); #1;
        chk(F_CNT, 0, "rst_cnt"); chk(F_RSP, 0, "rst_hresp"); chk(F_RDY, 1, "rst_hready");
        chk(F_WDQ, 0, "rst_wdq"); chk(F_ADQ, 0, "rst_adq"); chk(F_WR, 0, "rst_wr"); chk(F_PSZ, 0, "rst_psz");

        // Region decode
        drv(2'b10, 32'h8000_0000, 0, 1'b1, 3'd2, 1'b1, 1'b0);
        chk(F_SEL, 3'b001, "dec0_sel"); chk(F_VLD, 1, "dec0_vld"); chk(F_RSP, 0, "dec0_rsp");
        drv(2'b10, 32'h8400_0004, 0, 1'b0, 3'd1, 1'b1, 1'b0);
        chk(F_SEL, 3'b010, "dec1_sel"); chk(F_VLD, 1, "dec1_vld");
        chk(F_WR, 1, "dec1_wr"); chk(F_PSZ, 2, "dec1_psz"); chk(F_CNT, 1, "dec1_cnt");
        drv(2'b10, 32'h8800_0008, 0, 1'b1, 3'd0, 1'b1, 1'b0);
        chk(F_SEL, 3'b100, "dec2_sel"); chk(F_VLD, 1, "dec2_vld");
        chk(F_WR, 0, "dec2_wr"); chk(F_PSZ, 1, "dec2_psz"); chk(F_CNT, 2, "dec2_cnt");
        drv(2'b10, 32'h8C00_0000, 0, 1'b0, 3'd3, 1'b1, 1'b0);
        chk(F_SEL, 3'b000, "dec3_sel"); chk(F_VLD, 0, "dec3_vld"); chk(F_RDY, 1, "dec3_rdy");
        chk(F_RSP, 0, "dec3_rsp"); chk(F_CNT, 3, "dec3_cnt");

        // Error response
        drv(2'b00, 32'h0, 0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk(F_RDY, 0, "err1_rdy"); chk(F_RSP, 1, "err1_rsp");
        chk(F_CNT, 3, "err1_cnt"); chk(F_WR, 0, "err1_wr"); chk(F_PSZ, 3, "err1_psz");
        drv(2'b10, 32'h8000_0000, 0, 1'b1, 3'd2, 1'b1, 1'b0);
        chk(F_RDY, 1, "err2_rdy"); chk(F_RSP, 1, "err2_rsp"); chk(F_VLD, 0, "err2_vld");
        drv(2'b01, 32'h8000_0000, 0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk(F_RDY, 1, "post_err_rdy"); chk(F_RSP, 0, "post_err_rsp");
        chk(F_CNT, 3, "post_err_cnt"); chk(F_VLD, 0, "busy_vld"); chk(F_SEL, 3'b001, "busy_sel");

        // Delay lines
        drv(2'b00, 32'h100, 32'h11, 1'b0, 3'd0, 1'b1, 1'b0);
        drv(2'b00, 32'h200, 32'h22, 1'b0, 3'd0, 1'b1, 1'b0);
        drv(2'b00, 32'h300, 32'h33, 1'b0, 3'd0, 1'b1, 1'b0);
        drv(2'b10, 32'h8000_0000, 32'h44, 1'b1, 3'd2, 1'b0, 1'b0);
        prdata = 32'hDEAD_BEEF;
        chk(F_WDQ, 64'h0000_0022_0000_0033, "pipe_wdq"); chk(F_ADQ, 64'h0000_0200_0000_0300, "pipe_adq");
        chk(F_VLD, 0, "nrdy_vld"); chk(F_RD, 32'hDEAD_BEEF, "hrdata0");
        drv(2'b00, 32'h500, 32'h55, 1'b0, 3'd0, 1'b1, 1'b0);
        prdata = 32'h1234_5678;
        chk(F_WDQ, 64'h0000_0022_0000_0033, "pipe_hold_wdq"); chk(F_ADQ, 64'h0000_0200_0000_0300, "pipe_hold_adq");
        chk(F_CNT, 3, "nrdy_cnt"); chk(F_RD, 32'h1234_5678, "hrdata1");

        // Stall on an in-range transfer
        for (int i = 0; i < 3; i++) begin
            drv(2'b10, 32'h8400_0000, 0, 1'b1, 3'd2, 1'b1, 1'b1);
            chk(F_RDY, 0, "stall_rdy"); chk(F_VLD, 1, "stall_vld"); chk(F_CNT, 3, "stall_cnt");
            chk(F_WR, 0, "stall_wr"); chk(F_PSZ, 3, "stall_psz");
        end
        drv(2'b10, 32'h8400_0000, 0, 1'b1, 3'd2, 1'b1, 1'b0);
        chk(F_RDY, 1, "unstall_rdy"); chk(F_CNT, 3, "unstall_cnt0");
        drv(2'b00, 32'h0, 0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk(F_CNT, 4, "unstall_cnt1"); chk(F_WR, 1, "unstall_wr"); chk(F_PSZ, 2, "unstall_psz");

        // Stall on an out-of-range transfer, then reset inside ERR1
        for (int i = 0; i < 2; i++) begin
            drv(2'b10, 32'h8C00_0000, 0, 1'b0, 3'd1, 1'b1, 1'b1);
            chk(F_RDY, 0, "oor_stall_rdy"); chk(F_RSP, 0, "oor_stall_rsp");
        end
        drv(2'b10, 32'h8C00_0000, 0, 1'b0, 3'd1, 1'b1, 1'b0);
        chk(F_RDY, 1, "oor_go_rdy"); chk(F_RSP, 0, "oor_go_rsp");
        drv(2'b00, 32'h0, 0, 1'b0, 3'd0, 1'b1, 1'b0);
        hreset = 1'b1;
        chk(F_RSP, 0, "rst_err1_rsp"); chk(F_RDY, 1, "rst_err1_rdy"); chk(F_CNT, 0, "rst_err1_cnt");
        chk(F_PSZ, 0, "rst_err1_psz"); chk(F_WR, 0, "rst_err1_wr");
        drv(2'b00, 32'h0, 0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk(F_RSP, 0, "post_rst_rsp"); chk(F_RDY, 1, "post_rst_rdy");

        // Saturating counter
        drv(2'b10, 32'h8000_0000, 0, 1'b1, 3'd2, 1'b1, 1'b0);
        chk(F_CNT, 0, "cnt_start"); chk(F_VLD, 1, "cnt_vld");
        repeat (65534) @(posedge hclk);
        #1; chk(F_CNT, 16'hFFFE, "cnt_fffe");
        @(posedge hclk); #1; chk(F_CNT, 16'hFFFF, "cnt_ffff");
        repeat (2) @(posedge hclk);
        #1; chk(F_CNT, 16'hFFFF, "cnt_sat");
        drv(2'b00, 32'h0, 0, 1'b0, 3'd0, 1'b1, 1'b0);

        repeat (3) @(posedge hclk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
